debug_display_ctrl: RTL and testbench

Selects which of several 32-bit on-board debug sources (PC, instruction, ALU result, register/memory readback, ...) is driven onto the 8-digit hex seven-segment decoder. It sequences pages from a debounced push-button or an auto-cycle timer, supports a freeze/snapshot mode, and drives page-indicator LEDs. It sits between the processor's debug taps and the seven-segment decoder in the on-board top level.

---
 rtl/debug_display_ctrl.sv | 178 +++++++++++++++++
 tb/tb_debug_display_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/debug_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : debug_display_ctrl  (with helper debug_display_debounce)
// Purpose  : Picks one of NSRC 32-bit debug sources for the 8-digit hex
//            seven-segment decoder. Pages advance on a debounced push-button
//            or an auto-cycle timer; a second button toggles a freeze
//            (snapshot) mode. Page-indicator LEDs are driven one-hot.
// Ports    : clk         - system clock
//            reset_n     - synchronous active-low reset
//            src_val     - packed sources, source i = src_val[32*i +: 32]
//            btn_next    - raw async button, advance page
//            btn_freeze  - raw async button, toggle freeze
//            auto_en     - enables auto-cycling
//            debugval    - registered value to the seven-segment decoder
//            page        - current page index
//            page_onehot - LED indicator, bit[page] set
//            frozen      - freeze mode active
// Revision : 1.0 - initial release
// ============================================================================

// Two-FF synchronizer followed by a four-state debouncer. The press pulse is
// combinational on the WAIT_HI -> HIGH transition so it lines up with the
// edge at which the debounced level goes high.
module debug_display_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic press
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    WAIT_HI = 2'd1,
    HIGH    = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            sync_meta, sync;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      state     <= LOW;
      cnt       <= '0;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press     = 1'b0;
    case (state)
      LOW: begin
        if (sync) begin
          state_nxt = WAIT_HI;
          cnt_nxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!sync) begin
          state_nxt = LOW;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH;
          press     = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HIGH: begin
        if (!sync) begin
          state_nxt = WAIT_LO;
          cnt_nxt   = '0;
        end
      end
      WAIT_LO: begin
        if (sync) begin
          state_nxt = HIGH;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LOW;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = LOW;
    endcase
  end
endmodule

module debug_display_ctrl #(
  parameter int NSRC            = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_CYCLES     = 50000000,
  localparam int PW             = $clog2(NSRC)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NSRC*32-1:0]   src_val,
  input  logic                 btn_next,
  input  logic                 btn_freeze,
  input  logic                 auto_en,
  output logic [31:0]          debugval,
  output logic [PW-1:0]        page,
  output logic [NSRC-1:0]      page_onehot,
  output logic                 frozen
);
  localparam int AW = $clog2(AUTO_CYCLES);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_CYCLES - 1);
  localparam logic [PW-1:0] PAGE_LAST = PW'(NSRC - 1);

  logic          next_press, freeze_press;
  logic          frozen_nxt, tick, advance;
  logic [PW-1:0] page_nxt;
  logic [AW-1:0] auto_cnt, auto_cnt_nxt;
  logic [31:0]   sel_val;

  debug_display_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_next),
    .press   (next_press)
  );

  debug_display_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_freeze (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_freeze),
    .press   (freeze_press)
  );

  always_comb begin
    frozen_nxt   = frozen ^ freeze_press;
    tick         = auto_en && !frozen && (auto_cnt == AUTO_LAST);
    // Judging the advance against the post-toggle freeze state drops a
    // press that coincides with entering freeze but honours one that
    // coincides with leaving it.
    advance      = (next_press || tick) && !frozen_nxt;
    page_nxt     = page;
    if (advance) begin
      page_nxt = (page == PAGE_LAST) ? '0 : page + PW'(1);
    end
    auto_cnt_nxt = auto_cnt + 1'b1;
    if (!auto_en || frozen || next_press || tick) begin
      auto_cnt_nxt = '0;
    end
    sel_val      = src_val[32*int'(page) +: 32];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      page        <= '0;
      page_onehot <= NSRC'(1);
      debugval    <= '0;
      frozen      <= 1'b0;
      auto_cnt    <= '0;
    end else begin
      page        <= page_nxt;
      page_onehot <= NSRC'(1) << page_nxt;
      frozen      <= frozen_nxt;
      auto_cnt    <= auto_cnt_nxt;
      if (!frozen) begin
        debugval <= sel_val;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_debug_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_display_ctrl
// Purpose  : Self-checking bench for debug_display_ctrl with a behavioural
//            reference model compared every cycle plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_display_ctrl;
  localparam int NSRC = 4;
  localparam int DEB  = 4;
  localparam int AUTO = 10;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NSRC*32-1:0]  src_val;
  logic                btn_next, btn_freeze, auto_en;
  logic [31:0]         debugval;
  logic [1:0]          page;
  logic [NSRC-1:0]     page_onehot;
  logic                frozen;
  logic [31:0]         src [NSRC];

  int n_assert = 0;
  int n_fail   = 0;

  debug_display_ctrl #(
    .NSRC            (NSRC),
    .DEBOUNCE_CYCLES (DEB),
    .AUTO_CYCLES     (AUTO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .src_val     (src_val),
    .btn_next    (btn_next),
    .btn_freeze  (btn_freeze),
    .auto_en     (auto_en),
    .debugval    (debugval),
    .page        (page),
    .page_onehot (page_onehot),
    .frozen      (frozen)
  );

  always #5 clk = ~clk;

  always_comb begin
    src_val = '0;
    for (int i = 0; i < NSRC; i++) src_val[32*i +: 32] = src[i];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a button's debounced level flips once the synchronized
  // input (raw delayed two samples) has disagreed with it for DEB+1
  // consecutive samples; a flip to 1 is a press.
  logic [31:0] m_dbg;
  int          m_page, m_acnt;
  bit          m_frz;
  bit          m_h1 [2];
  bit          m_h2 [2];
  bit          m_lvl[2];
  int          m_run[2];
  bit          m_raw[2];
  bit          m_pr [2];
  bit          m_fz_new, m_tk, m_adv;

  always @(posedge clk) begin
    m_raw[0] = btn_next;
    m_raw[1] = btn_freeze;
    if (!reset_n) begin
      m_dbg = 0; m_page = 0; m_acnt = 0; m_frz = 0;
      for (int b = 0; b < 2; b++) begin
        m_h1[b] = 0; m_h2[b] = 0; m_lvl[b] = 0; m_run[b] = 0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        m_pr[b] = 0;
        if (m_h2[b] != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == DEB + 1) begin
            m_lvl[b] = m_h2[b];
            m_run[b] = 0;
            m_pr[b]  = m_lvl[b];
          end
        end else begin
          m_run[b] = 0;
        end
        m_h2[b] = m_h1[b];
        m_h1[b] = m_raw[b];
      end
      m_fz_new = m_frz ^ m_pr[1];
      m_tk     = auto_en && !m_frz && (m_acnt == AUTO - 1);
      m_adv    = (m_pr[0] || m_tk) && !m_fz_new;
      if (!m_frz) m_dbg = src[m_page];
      if (!auto_en || m_frz || m_pr[0] || m_tk) m_acnt = 0;
      else m_acnt++;
      if (m_adv) m_page = (m_page + 1) % NSRC;
      m_frz = m_fz_new;
    end
    #1;
    chk("model_page",   32'(page),        32'(m_page));
    chk("model_onehot", 32'(page_onehot), 32'(1) << m_page);
    chk("model_frozen", 32'(frozen),      32'(m_frz));
    chk("model_dbg",    debugval,         m_dbg);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press_next();
    btn_next = 1'b1; step(10);
    btn_next = 1'b0; step(10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NSRC; i++) src[i] = 32'h11111111 * i + 32'hA0000000;
    reset_n = 1'b0; btn_next = 1'b1; btn_freeze = 1'b1; auto_en = 1'b0;
    step(3);
    chk("rst_page",   32'(page),        32'd0);
    chk("rst_onehot", 32'(page_onehot), 32'd1);
    chk("rst_frozen", 32'(frozen),      32'd0);
    chk("rst_dbg",    debugval,         32'd0);
    reset_n = 1'b1; btn_next = 1'b0; btn_freeze = 1'b0;
    step(1);
    chk("first_dbg", debugval, 32'hA0000000);
    step(5);

    // Clean press: page at edge 7, debugval at edge 8, held gives one advance
    btn_next = 1'b1;
    step(6);
    chk("press_pre_page", 32'(page), 32'd0);
    step(1);
    chk("press_page", 32'(page), 32'd1);
    step(1);
    chk("press_dbg", debugval, 32'hB1111111);
    step(2);
    btn_next = 1'b0; step(10);
    chk("held_page", 32'(page), 32'd1);
    press_next(); press_next(); press_next();
    chk("wrap_page",   32'(page),        32'd0);
    chk("wrap_onehot", 32'(page_onehot), 32'd1);

    // Bounce then a stable level: exactly one advance
    begin
      logic [13:0] pat;
      pat = 14'b11111100110011;
      for (int i = 0; i < 14; i++) begin
        btn_next = pat[i];
        step(1);
      end
    end
    btn_next = 1'b0; step(10);
    chk("bounce_page", 32'(page), 32'd1);
    btn_next = 1'b1; step(3);
    btn_next = 1'b0; step(10);
    chk("glitch_page", 32'(page), 32'd1);

    // Auto-cycle from reset release
    reset_n = 1'b0; step(2);
    auto_en = 1'b1; reset_n = 1'b1;
    step(9);
    chk("auto_pre", 32'(page), 32'd0);
    step(1);
    chk("auto_1", 32'(page), 32'd1);
    step(10); chk("auto_2", 32'(page), 32'd2);
    step(10); chk("auto_3", 32'(page), 32'd3);
    step(10); chk("auto_0", 32'(page), 32'd0);
    // Press landing on the edge-50 tick: single advance, timer restarts
    step(3);
    btn_next = 1'b1; step(7);
    chk("aligned_page", 32'(page), 32'd1);
    step(3); btn_next = 1'b0; step(6);
    chk("restart_pre", 32'(page), 32'd1);
    step(1);
    chk("restart_page", 32'(page), 32'd2);
    auto_en = 1'b0;

    // Freeze on page 2
    btn_freeze = 1'b1; step(7);
    chk("freeze_on", 32'(frozen), 32'd1);
    step(3); btn_freeze = 1'b0; step(10);
    src[2] = 32'hDEADBEEF;
    press_next();
    chk("freeze_dbg",  debugval,   32'hC2222222);
    chk("freeze_page", 32'(page),  32'd2);
    btn_freeze = 1'b1; step(7);
    chk("freeze_off", 32'(frozen), 32'd0);
    step(1);
    chk("unfreeze_dbg", debugval, 32'hDEADBEEF);
    step(2); btn_freeze = 1'b0; step(10);

    // Reset mid-debounce and mid-auto-count
    reset_n = 1'b0; step(2);
    auto_en = 1'b1; reset_n = 1'b1;
    step(4);
    btn_next = 1'b1; step(3);
    reset_n = 1'b0; btn_next = 1'b0; step(2);
    reset_n = 1'b1;
    step(9);
    chk("midrst_page", 32'(page), 32'd0);
    step(1);
    chk("midrst_tick", 32'(page), 32'd1);
    auto_en = 1'b0; step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
